// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS count-up stopwatch.
// Digit codes feed the dec2_7seg decoders, where code 10 blanks a digit.
package stopwatch_pkg;

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   localparam logic [3:0] BCD_BLANK  = 4'd10;
   localparam logic [3:0] MAX_ONE    = 4'd9;
   localparam logic [3:0] MAX_TENSEC = 4'd5;

   // Anything outside 0-9 would mis-drive the decoder, so it is shown blank.
   function automatic logic [3:0] to_code(input logic [3:0] d);
      return (d > MAX_ONE) ? BCD_BLANK : d;
   endfunction

endpackage

// File: rtl/stopwatch_bcd_digit_counter.sv
// One BCD digit that wraps MAX->0.
// carry flags the wrap so the next digit can be chained off it.
module bcd_digit_counter #(
   parameter logic [3:0] MAX = 4'd9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   output logic [3:0] digit,
   output logic       carry
);

   assign carry = inc && (digit == MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      digit <= '0;
      else if (clr) digit <= '0;
      else if (inc) digit <= carry ? 4'd0 : digit + 4'd1;
   end

endmodule

// File: rtl/stopwatch_up.sv
// Count-up MM:SS stopwatch, 00:00 to 99:59, with run/pause, lap hold and clear.
// It saturates at 99:59 into DONE, where LEDR flashes once per second.
module stopwatch_up
   import stopwatch_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50000000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start_stop,
   input  logic       lap,
   input  logic       clear,
   output logic [3:0] tenmin,
   output logic [3:0] onemin,
   output logic [3:0] tensec,
   output logic [3:0] onesec,
   output logic       running,
   output logic       lap_active,
   output logic       done,
   output logic [9:0] LEDR
);

   localparam logic [25:0] PRE_MAX = 26'(TICKS_PER_SEC - 1);

   state_t      state, state_nxt;
   logic [25:0] presc;
   logic        advancing, tick, do_clear, at_max, enter_done, inc_sec;
   logic        lap_ok;
   logic        flash;
   logic [3:0]  os, ts, om, tm;
   logic        c_os, c_ts, c_om, carry_unused;
   logic [15:0] live, hold, src;

   assign live       = {tm, om, ts, os};
   assign advancing  = (state == RUN) || (state == DONE);
   assign tick       = advancing && (presc == PRE_MAX);
   // A clear while running is ignored.
   assign do_clear   = clear && (state != RUN);
   assign at_max     = (live == 16'h9959);
   assign enter_done = (state == RUN) && tick && at_max;
   assign inc_sec    = (state == RUN) && tick && !at_max;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!clear && start_stop) state_nxt = RUN;
         RUN:     if (tick && at_max)       state_nxt = DONE;
                  else if (start_stop)      state_nxt = PAUSE;
         PAUSE:   if (clear)                state_nxt = IDLE;
                  else if (start_stop)      state_nxt = RUN;
         DONE:    if (clear)                state_nxt = IDLE;
         default:                           state_nxt = IDLE;
      endcase
   end

   // Held while paused so that a resumed run completes the partial second.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)                        presc <= '0;
      else if (do_clear || enter_done) presc <= '0;
      else if (tick)                   presc <= '0;
      else if (advancing)              presc <= presc + 26'd1;
   end

   bcd_digit_counter #(.MAX(MAX_ONE)) u_onesec (
      .clk(CLOCK_50), .rst(reset), .inc(inc_sec), .clr(do_clear), .digit(os), .carry(c_os));
   bcd_digit_counter #(.MAX(MAX_TENSEC)) u_tensec (
      .clk(CLOCK_50), .rst(reset), .inc(c_os), .clr(do_clear), .digit(ts), .carry(c_ts));
   bcd_digit_counter #(.MAX(MAX_ONE)) u_onemin (
      .clk(CLOCK_50), .rst(reset), .inc(c_ts), .clr(do_clear), .digit(om), .carry(c_om));
   bcd_digit_counter #(.MAX(MAX_ONE)) u_tenmin (
      .clk(CLOCK_50), .rst(reset), .inc(c_om), .clr(do_clear), .digit(tm), .carry(carry_unused));

   // In RUN a simultaneous start_stop drops the lap pulse.
   assign lap_ok = lap && (((state == RUN) && !start_stop) || (state == PAUSE));

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         lap_active <= 1'b0;
         hold       <= '0;
      end else if (do_clear || enter_done) begin
         lap_active <= 1'b0;
      end else if (lap_ok && lap_active) begin
         lap_active <= 1'b0;
      end else if (lap_ok && (state == RUN)) begin
         lap_active <= 1'b1;
         hold       <= live;
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)                        flash <= 1'b0;
      else if (state != DONE || clear) flash <= 1'b0;
      else if (tick)                   flash <= ~flash;
   end

   assign src = lap_active ? hold : live;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         tenmin <= '0;
         onemin <= '0;
         tensec <= '0;
         onesec <= '0;
      end else begin
         tenmin <= to_code(src[15:12]);
         onemin <= to_code(src[11:8]);
         tensec <= to_code(src[7:4]);
         onesec <= to_code(src[3:0]);
      end
   end

   assign running = (state == RUN);
   assign done    = (state == DONE);
   assign LEDR    = {10{flash}};

endmodule

// File: tb/tb_stopwatch_up.sv
// Directed bench for stopwatch_up with TICKS_PER_SEC=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_stopwatch_up;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1, start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
   logic [3:0] tenmin, onemin, tensec, onesec;
   logic       running, lap_active, done;
   logic [9:0] LEDR;
   logic [15:0] disp;
   int total = 0, bad = 0;

   stopwatch_up #(.TICKS_PER_SEC(4)) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .start_stop(start_stop), .lap(lap),
      .clear(clear), .tenmin(tenmin), .onemin(onemin), .tensec(tensec),
      .onesec(onesec), .running(running), .lap_active(lap_active), .done(done),
      .LEDR(LEDR));

   always #5 CLOCK_50 = ~CLOCK_50;
   assign disp = {tenmin, onemin, tensec, onesec};

   task automatic step(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1; step(1); start_stop = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; step(2); reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; step(2);
      total++; if (disp !== 16'h0000) begin bad++; $display("FAIL reset_disp got=%h want=0000", disp); end
      total++; if ({running, lap_active, done} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {running, lap_active, done}); end
      total++; if (LEDR !== 10'h000) begin bad++; $display("FAIL reset_ledr got=%h want=000", LEDR); end
      reset = 1'b0; step(3);
      total++; if (disp !== 16'h0000 || running !== 1'b0) begin bad++; $display("FAIL idle_hold got=%h/%b want=0000/0", disp, running); end
   endtask

   task automatic test_run();
      do_reset(); pulse_ss(); step(41);
      total++; if (disp !== 16'h0010) begin bad++; $display("FAIL run40 got=%h want=0010", disp); end
      total++; if (running !== 1'b1) begin bad++; $display("FAIL run_flag got=%b want=1", running); end
   endtask

   task automatic test_pause();
      do_reset(); pulse_ss(); step(5); pulse_ss(); step(20);
      total++; if (disp !== 16'h0001 || running !== 1'b0) begin bad++; $display("FAIL pause_hold got=%h/%b want=0001/0", disp, running); end
      pulse_ss(); step(2);
      total++; if (disp !== 16'h0001 || running !== 1'b1) begin bad++; $display("FAIL resume_early got=%h/%b want=0001/1", disp, running); end
      step(1);
      total++; if (disp !== 16'h0002) begin bad++; $display("FAIL resume_tick got=%h want=0002", disp); end
      step(3);
      total++; if (disp !== 16'h0002) begin bad++; $display("FAIL resume_gap got=%h want=0002", disp); end
      step(1);
      total++; if (disp !== 16'h0003) begin bad++; $display("FAIL resume_next got=%h want=0003", disp); end
   endtask

   task automatic test_carry();
      do_reset(); pulse_ss(); step(237);
      total++; if (disp !== 16'h0059) begin bad++; $display("FAIL carry_0059 got=%h want=0059", disp); end
      step(4);
      total++; if (disp !== 16'h0100) begin bad++; $display("FAIL carry_0100 got=%h want=0100", disp); end
      step(2156);
      total++; if (disp !== 16'h0959) begin bad++; $display("FAIL carry_0959 got=%h want=0959", disp); end
      step(4);
      total++; if (disp !== 16'h1000) begin bad++; $display("FAIL carry_1000 got=%h want=1000", disp); end
   endtask

   task automatic test_lap();
      do_reset(); pulse_ss(); step(13);
      total++; if (disp !== 16'h0003) begin bad++; $display("FAIL lap_pre got=%h want=0003", disp); end
      lap = 1'b1; step(1); lap = 1'b0; step(8);
      total++; if (disp !== 16'h0003 || lap_active !== 1'b1) begin bad++; $display("FAIL lap_hold got=%h/%b want=0003/1", disp, lap_active); end
      lap = 1'b1; step(1); lap = 1'b0; step(1);
      total++; if (disp !== 16'h0005 || lap_active !== 1'b0) begin bad++; $display("FAIL lap_release got=%h/%b want=0005/0", disp, lap_active); end
   endtask

   task automatic test_done();
      do_reset(); pulse_ss(); step(23997);
      total++; if (disp !== 16'h9959 || done !== 1'b0) begin bad++; $display("FAIL pre_done got=%h/%b want=9959/0", disp, done); end
      step(3);
      total++; if ({running, done} !== 2'b01 || disp !== 16'h9959) begin bad++; $display("FAIL done_entry got=%b/%h want=01/9959", {running, done}, disp); end
      step(3);
      total++; if (LEDR !== 10'h000) begin bad++; $display("FAIL ledr_off got=%h want=000", LEDR); end
      step(1);
      total++; if (LEDR !== 10'h3ff) begin bad++; $display("FAIL ledr_on got=%h want=3ff", LEDR); end
      step(4);
      total++; if (LEDR !== 10'h000 || disp !== 16'h9959) begin bad++; $display("FAIL ledr_off2 got=%h/%h want=000/9959", LEDR, disp); end
      clear = 1'b1; step(1); clear = 1'b0;
      total++; if (done !== 1'b0 || LEDR !== 10'h000) begin bad++; $display("FAIL done_clear got=%b/%h want=0/000", done, LEDR); end
      step(1);
      total++; if (disp !== 16'h0000) begin bad++; $display("FAIL done_clear_disp got=%h want=0000", disp); end
   endtask

   task automatic test_back_to_back();
      do_reset(); pulse_ss(); step(10);
      #2 reset = 1'b1; #1;
      total++; if (disp !== 16'h0000 || {running, lap_active, done} !== 3'b000 || LEDR !== 10'h000) begin
         bad++; $display("FAIL async_reset got=%h/%b want=0000/000", disp, {running, lap_active, done}); end
      #1 reset = 1'b0; step(2);
      total++; if (disp !== 16'h0000 || running !== 1'b0) begin bad++; $display("FAIL post_reset got=%h/%b want=0000/0", disp, running); end
      pulse_ss(); step(5); pulse_ss(); step(1);
      total++; if (disp !== 16'h0001 || running !== 1'b0) begin bad++; $display("FAIL paused got=%h/%b want=0001/0", disp, running); end
      clear = 1'b1; start_stop = 1'b1; step(1); clear = 1'b0; start_stop = 1'b0;
      total++; if (running !== 1'b0) begin bad++; $display("FAIL clear_beats_ss got=%b want=0", running); end
      step(1);
      total++; if (disp !== 16'h0000) begin bad++; $display("FAIL clear_zero got=%h want=0000", disp); end
      step(8);
      total++; if (disp !== 16'h0000 || running !== 1'b0) begin bad++; $display("FAIL clear_idle got=%h/%b want=0000/0", disp, running); end
   endtask

   initial begin
      test_reset();
      test_run();
      test_pause();
      test_carry();
      test_lap();
      test_done();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_up.md
# stopwatch_up

Count-up MM:SS stopwatch, the counterpart of the existing countdown timer: counts up from 00:00 to 99:59 on a 1 Hz tick derived from CLOCK_50, with start/stop, lap-hold and clear controls. It drives four BCD digit codes into the existing dec2_7seg decoders (code 10 blanks a digit) and flashes LEDR on overflow. Control inputs are single-cycle pulses from an upstream key edge detector.

## Interface
- TICKS_PER_SEC, 50000000, CLOCK_50 cycles per counted second; ≥2; simulation uses 4.
- CLOCK_50  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high; clears every register.
- start_stop  input  1  one-cycle pulse that toggles between run and pause.
- lap  input  1  one-cycle pulse that toggles the lap hold.
- clear  input  1  one-cycle pulse that zeroes the count when the stopwatch is not running.
- tenmin, onemin, tensec, onesec  output  4 each  registered BCD display codes, 0–9.
- running  output  1  high while in RUN.
- lap_active  output  1  high while the display is frozen by a lap hold.
- done  output  1  high in DONE.
- LEDR  output  10  all ones or all zeros; flashes in DONE.

## Operation
- States:
  - IDLE: reset state; count 00:00.
  - RUN: counting.
  - PAUSE: count held.
  - DONE: overflow reached.
- Transitions:
  - IDLE→RUN on start_stop.
  - RUN→PAUSE on start_stop.
  - PAUSE→RUN on start_stop.
  - RUN→DONE on a tick when the count is 99:59.
  - DONE→IDLE on clear.
  - IDLE/PAUSE→IDLE on clear, with the count zeroed.
- Prescaler:
  - 26-bit counter, 0..TICKS_PER_SEC-1.
  - Advances in RUN and in DONE.
  - Holds in IDLE and PAUSE, so a resumed run completes the partial second.
  - Zeroed by clear, by reset, and on entry to DONE.
  - tick = prescaler == TICKS_PER_SEC-1 while advancing; the prescaler wraps to 0 on that cycle.
- Count (RUN only, on tick):
  - onesec 9→0 carries into tensec.
  - tensec 5→0 carries into onemin.
  - onemin 9→0 carries into tenmin.
  - At 99:59 the count does not wrap: it saturates at 99:59 and the state goes to DONE.
- Lap:
  - In RUN, lap with lap_active=0 snapshots the live count into the hold registers and sets lap_active.
  - lap with lap_active=1 releases the hold, in RUN or PAUSE.
  - lap in IDLE or DONE is ignored.
  - clear releases the hold.
- Display outputs show the snapshot when lap_active=1, otherwise the live count. The blank code 10 is never emitted.
- DONE:
  - flash bit toggles on each tick.
  - LEDR = {10{flash}}.
  - done=1; the display shows 99:59.
- Simultaneous events:
  - In RUN, start_stop beats lap; the lap pulse is dropped.
  - In RUN, clear is ignored.
  - In IDLE or PAUSE, clear beats start_stop; the result is IDLE with a zeroed count.
  - A tick coinciding with start_stop in RUN is counted first, then the state pauses.
- Reset mid-operation: immediate return to IDLE, with count, prescaler, snapshot, flash and all outputs zeroed.

## Timing
- Reset values:
  - all digit outputs 0.
  - running=0, lap_active=0, done=0.
  - LEDR=10'b0.
- State, count and prescaler update on the same edge that samples the pulse or tick.
- running, lap_active and done are decoded directly from registers, so they are valid in the cycle after the sampling edge.
- Digit outputs are re-registered, one further cycle of latency: a tick at edge N shows on the digits after edge N+1.
- Input pulses must be exactly one cycle wide. A level held high toggles every cycle; this is documented behaviour, not guarded against.
- First counted second after IDLE→RUN takes exactly TICKS_PER_SEC cycles.

## Structure
- Shared package stopwatch_pkg holds:
  - the state enum IDLE/RUN/PAUSE/DONE.
  - BCD_BLANK = 4'd10.
  - digit limits MAX_ONE = 9 and MAX_TENSEC = 5.
- One sub-module, bcd_digit_counter:
  - parameter MAX.
  - inputs: inc, clr.
  - outputs: digit[3:0] and carry (asserted when inc and digit==MAX).
  - instantiated four times, chained by carry.
- Saturation at 99:59 is handled in the top level by masking inc.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset then start_stop, run 40 cycles → digits 00:10; running=1.
- Pause after 6 cycles, wait 20, resume → next increment lands 2 cycles after resume; no tick is lost or duplicated.
- Preload 00:59 in RUN, one tick → 01:00. Preload 09:59, one tick → 10:00.
- lap at 00:03 in RUN, run 8 more cycles → display holds 00:03 with lap_active=1; second lap → display 00:05.
- Run to 99:59 plus one tick → state DONE, display 99:59, done=1, LEDR toggles all-ones/zeros every 4 cycles; clear → IDLE, 00:00, LEDR=0.
- Assert reset mid-RUN asynchronously between edges → all outputs 0 immediately; clear and start_stop in the same cycle in PAUSE → IDLE, 00:00.
